// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction fields into 32-bit words and streams
// them, with byte addresses, into a small output FIFO for instruction-memory
// preload. Illegal field sets are consumed but dropped and counted.
//
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      field-set handshake (in_ready is combinational)
//   in_kind, in_funct3,    instruction kind (0 reg,1 imm,2 jal,3 jalr,
//   in_sub, in_rd, in_rs1,   4 branch,5 load,6 store,7 illegal) and fields
//   in_rs2, in_imm
//   out_valid/out_ready    FIFO head handshake
//   out_data, out_addr     head word and its byte address
//   err_flag, err_count    sticky reject flag, saturating reject count
//   flush, pad_busy        NOP padding request / padding in progress
//
// Optional feature: define ENC_NOP_PAD_EN to enable NOP padding to a
// PAD_WORDS-aligned block on flush. Without it flush is ignored and
// pad_busy is tied low.
module instr_encoder #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                PAD_WORDS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [2:0]        in_funct3,
    input  logic              in_sub,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_flag,
    output logic [7:0]        err_count,
    input  logic              flush,
    output logic              pad_busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam logic [2:0] K_REG = 3'd0, K_IMM = 3'd1, K_JAL = 3'd2, K_JALR = 3'd3,
                           K_BR  = 3'd4, K_LD  = 3'd5, K_ST  = 3'd6;

    typedef enum logic {RUN, PAD} state_t;

    // Returns {legal, word}. Unused fields of each format are simply not packed.
    function automatic logic [32:0] encode(input logic [2:0] kind, input logic [2:0] f3,
                                           input logic sub, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic signed [31:0] imm);
        logic        ok;
        logic [31:0] w;
        logic        i_ok, b_ok, j_ok;
        i_ok = (imm >= -32'sd2048) && (imm <= 32'sd2047);
        b_ok = (imm >= -32'sd4096) && (imm <= 32'sd4094) && !imm[0];
        j_ok = (imm >= -32'sd1048576) && (imm <= 32'sd1048574) && !imm[0];
        ok = 1'b1;
        w  = '0;
        case (kind)
            K_REG:  w = {(sub ? 7'h20 : 7'h00), rs2, rs1, f3, rd, 7'h33};
            K_IMM:  begin ok = i_ok; w = {imm[11:0], rs1, f3, rd, 7'h13}; end
            K_JAL:  begin ok = j_ok;
                          w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F}; end
            K_JALR: begin ok = i_ok; w = {imm[11:0], rs1, 3'b000, rd, 7'h67}; end
            K_BR:   begin
                ok = b_ok && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5);
                w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
            end
            K_LD:   begin ok = i_ok && (f3 <= 3'd2); w = {imm[11:0], rs1, f3, rd, 7'h03}; end
            K_ST:   begin ok = i_ok && (f3 <= 3'd2);
                          w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23}; end
            default: ok = 1'b0;
        endcase
        return {ok, w};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [31:0]        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;
    state_t             state;

    logic signed [31:0] imm_p0;
    logic [32:0]        enc_p0;
    logic               enc_ok_p0;
    logic [31:0]        enc_word_p0;
    logic               accept, push, pop, push_nop;
    logic [31:0]        push_word;

    // Stage p0: combinational field packing and legality check
    assign imm_p0      = $signed(in_imm);
    assign enc_p0      = encode(in_kind, in_funct3, in_sub, in_rd, in_rs1, in_rs2, imm_p0);
    assign enc_ok_p0   = enc_p0[32];
    assign enc_word_p0 = enc_p0[31:0];

    assign in_ready  = (count < DEPTH_C) && (state == RUN);
    assign accept    = in_valid && in_ready;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

`ifdef ENC_NOP_PAD_EN
    localparam int CNT_W = (PAD_WORDS > 1) ? $clog2(PAD_WORDS) : 1;
    logic [CNT_W-1:0] enq_cnt;
    logic             aligned, aligned_next;
    // enq_cnt wraps modulo PAD_WORDS because PAD_WORDS is a power of 2
    assign aligned      = (PAD_WORDS == 1) || (enq_cnt == '0);
    assign aligned_next = (PAD_WORDS == 1) || ((enq_cnt + CNT_W'(1)) == '0);
    assign push_nop     = (state == PAD) && !aligned && (count < DEPTH_C);
    assign pad_busy     = (state == PAD);
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign push_nop     = 1'b0;
    assign pad_busy     = 1'b0;
`endif

    // In PAD in_ready is low, so an accepted word and a NOP never collide
    assign push      = (accept && enc_ok_p0) || push_nop;
    assign push_word = push_nop ? NOP_WORD : enc_word_p0;

    // Stage p1: output FIFO, address counter, error bookkeeping, pad FSM
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_addr  <= BASE_ADDR;
            err_flag  <= 1'b0;
            err_count <= '0;
            state     <= RUN;
`ifdef ENC_NOP_PAD_EN
            enq_cnt   <= '0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                out_addr <= out_addr + ADDR_W'(4);
            end
            if (push && !pop)      count <= count + (PTR_W+1)'(1);
            else if (!push && pop) count <= count - (PTR_W+1)'(1);
            if (accept && !enc_ok_p0) begin
                err_flag  <= 1'b1;
                err_count <= sat_inc(err_count);
            end
`ifdef ENC_NOP_PAD_EN
            if (push) enq_cnt <= enq_cnt + CNT_W'(1);
            case (state)
                RUN: if (flush) state <= PAD;
                PAD: begin
                    // Leave as soon as the block is aligned, including on the
                    // cycle the final NOP is written
                    if (aligned || (push_nop && aligned_next)) state <= RUN;
                end
                default: state <= RUN;
            endcase
`else
            state <= RUN;
`endif
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [2:0]  in_kind = '0, in_funct3 = '0;
    logic        in_sub = 1'b0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_data;
    logic [31:0] out_addr;
    logic        err_flag;
    logic [7:0]  err_count;
    logic        flush = 1'b0, pad_busy;

    always #5 clock = ~clock;

    instr_encoder dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_sub(in_sub),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr),
        .err_flag(err_flag), .err_count(err_count),
        .flush(flush), .pad_busy(pad_busy)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_addr = '0;
    logic        stall_prev = 1'b0;
    logic [31:0] hold_data, hold_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every head transfer
    always @(negedge clock) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (out_valid && !out_ready && stall_prev) begin
                check("hold_data", out_data, hold_data);
                check("hold_addr", out_addr, hold_addr);
            end
            stall_prev = out_valid && !out_ready;
            hold_data  = out_data;
            hold_addr  = out_addr;
            if (out_valid && out_ready) begin
                check("sb_has_entry", {31'b0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) check("out_data", out_data, sb.pop_front());
                check("out_addr", out_addr, exp_addr);
                exp_addr = exp_addr + 32'd4;
            end
        end
    end

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        sb.delete();
        exp_addr = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Present one field set; push the expected word if it should be accepted
    task automatic send(input logic [2:0] k, input logic [2:0] f3, input logic s,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic ok, input logic [31:0] word);
        int n = 0;
        in_kind = k; in_funct3 = f3; in_sub = s;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        @(negedge clock);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clock);
        end
        if (!in_ready) begin
            check("ready_timeout", n, 0);
            @(posedge clock); #1 in_valid = 1'b0;
            return;
        end
        if (ok) sb.push_back(word);
        @(posedge clock); #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 100) begin
            n++;
            @(negedge clock);
        end
        @(negedge clock);
        check("drain_empty", sb.size(), 0);
        check("drain_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got 0x00000001, want 0x00000000");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        do_reset();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_addr", out_addr, 32'd0);
        check("rst_err_flag", {31'b0, err_flag}, 32'd0);
        check("rst_err_count", {24'b0, err_count}, 32'd0);
        check("rst_pad_busy", {31'b0, pad_busy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Encodings of each kind, with one-cycle latency and a reject mid-stream
        out_ready = 1'b1;
        send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
        check("lat_valid", {31'b0, out_valid}, 32'd1);
        check("lat_data", out_data, 32'h002081B3);
        send(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h402081B3);
        send(3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF00293);
        send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h00208463);
        send(3'd2, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 32'h001000EF);
        send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'h0);
        check("rej_err_flag", {31'b0, err_flag}, 32'd1);
        check("rej_err_count", {24'b0, err_count}, 32'd1);
        send(3'd5, 3'd2, 1'b0, 5'd6, 5'd7, 5'd0, 32'd12, 1'b1, 32'h00C3A303);
        send(3'd6, 3'd2, 1'b0, 5'd0, 5'd2, 5'd5, 32'hFFFFFFFC, 1'b1, 32'hFE512E23);
        send(3'd3, 3'd0, 1'b0, 5'd1, 5'd5, 5'd0, 32'h10, 1'b1, 32'h010280E7);
        // Immediate range boundaries that are still legal
        send(3'd1, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd2047, 1'b1, 32'h7FF08093);
        send(3'd1, 3'd7, 1'b0, 5'd2, 5'd3, 5'd0, 32'hFFFFF800, 1'b1, 32'h8001F113);
        send(3'd4, 3'd1, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFF000, 1'b1, 32'h80001063);
        send(3'd4, 3'd5, 1'b0, 5'd0, 5'd3, 5'd4, 32'd4094, 1'b1, 32'h7E41DFE3);
        send(3'd2, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFF00000, 1'b1, 32'h8000006F);
        send(3'd2, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h000FFFFE, 1'b1, 32'h7FFFF06F);
        drain();

        // Reject rules, then saturation of the reject counter
        do_reset();
        send(3'd7, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 32'h0);
        send(3'd4, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h0);
        send(3'd5, 3'd3, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0, 1'b0, 32'h0);
        send(3'd6, 3'd4, 1'b0, 5'd0, 5'd1, 5'd2, 32'd0, 1'b0, 32'h0);
        send(3'd1, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd2048, 1'b0, 32'h0);
        send(3'd1, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'hFFFFF7FF, 1'b0, 32'h0);
        send(3'd6, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd2048, 1'b0, 32'h0);
        send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4096, 1'b0, 32'h0);
        send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFEFFE, 1'b0, 32'h0);
        send(3'd2, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00100000, 1'b0, 32'h0);
        send(3'd2, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0);
        check("rej_count_11", {24'b0, err_count}, 32'd11);
        check("rej_no_output", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
        for (int i = 0; i < 250; i++)
            send(3'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0);
        check("err_count_sat", {24'b0, err_count}, 32'd255);
        check("err_flag_sticky", {31'b0, err_flag}, 32'd1);
        drain();

        // Back-pressure: fill the FIFO, then release
        do_reset();
        out_ready = 1'b0;
        send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b1, 32'h00100093);
        send(3'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2, 1'b1, 32'h00200113);
        send(3'd1, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd3, 1'b1, 32'h00300193);
        send(3'd1, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 32'd4, 1'b1, 32'h00400213);
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        check("full_head_addr", out_addr, 32'd0);
        repeat (3) @(posedge clock);
        #1 out_ready = 1'b1;
        send(3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500293);
        drain();
        check("wrap_addr_after5", out_addr, 32'h14);

`ifdef ENC_NOP_PAD_EN
        // One word then flush: three NOPs complete the 4-word block
        do_reset();
        out_ready = 1'b1;
        send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
        flush = 1'b1;
        repeat (3) sb.push_back(32'h00000013);
        @(posedge clock); #1 flush = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (i == 0) check("pad_in_ready", {31'b0, in_ready}, 32'd0);
            if (!pad_busy) break;
            n++;
        end
        check("pad_cycles_ge3", {31'b0, n >= 3}, 32'd1);
        // Already aligned: one PAD cycle, no NOPs
        @(posedge clock); #1 flush = 1'b1;
        @(posedge clock); #1 flush = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!pad_busy) break;
            n++;
        end
        check("pad_aligned_cycles", n, 1);
        drain();

        // Reset in the middle of padding discards everything queued
        do_reset();
        out_ready = 1'b0;
        send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b1, 32'h00100093);
        send(3'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2, 1'b1, 32'h00200113);
        flush = 1'b1;
        @(posedge clock); #1 flush = 1'b0;
        check("pad_started", {31'b0, pad_busy}, 32'd1);
        reset = 1'b1;
        sb.delete();
        exp_addr = '0;
        @(posedge clock); #1;
        check("rst_pad_valid", {31'b0, out_valid}, 32'd0);
        check("rst_pad_busy", {31'b0, pad_busy}, 32'd0);
        reset = 1'b0;
        check("rst_pad_addr", out_addr, 32'd0);
        out_ready = 1'b1;
        send(3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF00293);
        drain();
`else
        // Padding disabled: flush has no effect
        do_reset();
        out_ready = 1'b1;
        send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("nopad_busy", {31'b0, pad_busy}, 32'd0);
            check("nopad_in_ready", {31'b0, in_ready}, 32'd1);
        end
        @(posedge clock); #1 flush = 1'b0;
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
